// File: rtl/sdram_pkg.sv
// Shared SDRAM controller types: command encodings {cs_n,ras_n,cas_n,we_n},
// arbiter state encoding and the default data width.
package sdram_pkg;

  localparam int DQ_W_DEF = 16;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_MRS  = 4'b0000;

  typedef enum logic [2:0] {
    S_INIT  = 3'd0,
    S_ARBIT = 3'd1,
    S_AREF  = 3'd2,
    S_WRITE = 3'd3,
    S_READ  = 3'd4
  } state_t;

  typedef enum logic {
    GR_WR = 1'b0,
    GR_RD = 1'b1
  } grant_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [11:0] addr;
  } cmd_t;

endpackage

// File: rtl/sdram_arbit.sv
// SDRAM command-bus arbiter: init, then refresh > write/read (alternating); grant 1 cycle after ask, stage->pin 1 cycle.
// No backpressure: stages hold ask until granted, refresh drops an active wr/rd grant so the stage stops at a burst boundary.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter int         DQ_W = DQ_W_DEF,
  parameter logic [1:0] BANK = 2'b00
) (
  input  logic            sclk,
  input  logic            srst,
  input  logic            init_end,
  input  logic [3:0]      init_cmd,
  input  logic [11:0]     init_addr,
  input  logic            ref_req,
  output logic            ref_en,
  input  logic            ref_end,
  input  logic [3:0]      ref_cmd,
  input  logic [11:0]     ref_addr,
  input  logic            wr_ask,
  output logic            wr_en,
  input  logic            wr_end,
  input  logic [3:0]      wr_cmd,
  input  logic [11:0]     wr_addr,
  input  logic [DQ_W-1:0] wr_dq,
  input  logic            wr_dq_en,
  input  logic            rd_ask,
  output logic            rd_en,
  input  logic            rd_end,
  input  logic [3:0]      rd_cmd,
  input  logic [11:0]     rd_addr,
  output logic            sdram_cke,
  output logic            sdram_cs_n,
  output logic            sdram_ras_n,
  output logic            sdram_cas_n,
  output logic            sdram_we_n,
  output logic [1:0]      sdram_bank,
  output logic [11:0]     sdram_addr,
  output logic [DQ_W-1:0] sdram_dq_out,
  output logic            sdram_dq_oe
);

  state_t state, state_nxt;
  grant_t last_grant;
  cmd_t   sel;

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) state <= S_INIT;
    else      state <= state_nxt;
  end

  // Every end edge returns to S_ARBIT, which guarantees a NOP cycle between operations.
  always_comb begin
    state_nxt = state;
    sel       = '{cmd: CMD_NOP, addr: 12'd0};
    case (state)
      S_INIT: begin
        sel = '{cmd: init_cmd, addr: init_addr};
        if (init_end) state_nxt = S_ARBIT;
      end
      S_ARBIT: begin
        if (ref_req)               state_nxt = S_AREF;
        else if (wr_ask && rd_ask) state_nxt = (last_grant == GR_RD) ? S_WRITE : S_READ;
        else if (wr_ask)           state_nxt = S_WRITE;
        else if (rd_ask)           state_nxt = S_READ;
      end
      S_AREF: begin
        sel = '{cmd: ref_cmd, addr: ref_addr};
        if (ref_end) state_nxt = S_ARBIT;
      end
      S_WRITE: begin
        sel = '{cmd: wr_cmd, addr: wr_addr};
        if (wr_end) state_nxt = S_ARBIT;
      end
      S_READ: begin
        sel = '{cmd: rd_cmd, addr: rd_addr};
        if (rd_end) state_nxt = S_ARBIT;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  always_ff @(posedge sclk or posedge srst) begin
    if (srst) begin
      ref_en       <= 1'b0;
      wr_en        <= 1'b0;
      rd_en        <= 1'b0;
      last_grant   <= GR_RD;
      sdram_cke    <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= 4'b1111;
      sdram_addr   <= 12'd0;
      sdram_bank   <= BANK;
      sdram_dq_out <= '0;
      sdram_dq_oe  <= 1'b0;
    end else begin
      ref_en <= (state_nxt == S_AREF);
      wr_en  <= (state_nxt == S_WRITE) && !ref_req;
      rd_en  <= (state_nxt == S_READ)  && !ref_req;
      if (state == S_ARBIT && state_nxt == S_WRITE) last_grant <= GR_WR;
      if (state == S_ARBIT && state_nxt == S_READ)  last_grant <= GR_RD;
      sdram_cke    <= 1'b1;
      // Command, data and oe share one register stage so data lines up with the WRITE command.
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= sel.cmd;
      sdram_addr   <= sel.addr;
      sdram_bank   <= BANK;
      sdram_dq_out <= wr_dq;
      sdram_dq_oe  <= (state == S_WRITE) && wr_dq_en;
    end
  end

endmodule

// File: doc/sdram_arbit.md
Name: sdram_arbit

Overview:
- Top-level command arbiter of the SDRAM controller.
- Sequences the init stage, then grants the SDRAM command bus to auto-refresh, write or read through en/ask/end handshakes.
- Muxes the granted stage's cmd/addr/data onto registered SDRAM pins.
- Sits directly upstream of sdram_write: it drives wr_en and consumes flag_wr_ask, flag_wr_end, sdram_cmd, sdram_addr and write data.

Parameters:
- DQ_W, 16, SDRAM data width.
- BANK, 2'b00, bank address driven with every command.

Ports:
- sclk  in  1  system clock
- srst  in  1  asynchronous active-high reset
- init_end  in  1  init sequence done, one-cycle pulse
- init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
- init_addr  in  12  init address
- ref_req  in  1  refresh due, level, held until served
- ref_en  out  1  refresh grant
- ref_end  in  1  refresh done pulse
- ref_cmd  in  4  refresh command
- ref_addr  in  12  refresh address
- wr_ask  in  1  write stage request (flag_wr_ask)
- wr_en  out  1  write grant
- wr_end  in  1  write stage done pulse (flag_wr_end)
- wr_cmd  in  4  write command
- wr_addr  in  12  write address
- wr_dq  in  DQ_W  write data
- wr_dq_en  in  1  write data valid (wr_data_en)
- rd_ask  in  1  read stage request
- rd_en  out  1  read grant
- rd_end  in  1  read done pulse
- rd_cmd  in  4  read command
- rd_addr  in  12  read address
- sdram_cke  out  1  clock enable
- sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  out  1 each  command pins
- sdram_bank  out  2  bank
- sdram_addr  out  12  address
- sdram_dq_out  out  DQ_W  data to pad
- sdram_dq_oe  out  1  pad output enable

Behaviour:
- Reset (srst async, active-high) values:
  - state=S_INIT; ref_en, wr_en, rd_en=0.
  - cmd pins=1111; sdram_addr=0; sdram_bank=BANK.
  - dq_out=0; dq_oe=0; sdram_cke=0; last_grant=RD.
- sdram_cke: goes to 1 on the first sclk edge after srst deasserts and stays 1.
- States: S_INIT, S_ARBIT, S_AREF, S_WRITE, S_READ.
- S_INIT: mux init_cmd/init_addr; on init_end -> S_ARBIT. ref/wr/rd asks are ignored.
- S_ARBIT: internal cmd is NOP (0111), addr 0. The decision is made on the sampled inputs:
  - ref_req -> S_AREF.
  - else wr_ask and rd_ask together -> grant opposite of last_grant.
  - else wr_ask -> S_WRITE.
  - else rd_ask -> S_READ.
  - else stay.
- Grant outputs are registered: the en output rises on the edge that enters the state, so grant latency is 1 cycle from the sampled ask. last_grant updates on a WR/RD grant.
- S_AREF: ref_en=1; mux ref_cmd/ref_addr; on ref_end -> S_ARBIT, ref_en=0 on the same edge.
- S_WRITE: mux wr_cmd/wr_addr.
  - wr_en = 1 & ~ref_req, registered: ref_req arriving mid-write drops wr_en next cycle so the write stage stops at its burst boundary.
  - Stay until wr_end -> S_ARBIT, wr_en=0.
  - The write stage keeps wr_ask high if data remains; the refresh then wins arbitration and the write resumes after.
- S_READ: identical to S_WRITE with rd_* signals.
- Simultaneous end and new ask: the end edge always returns to S_ARBIT. At least one NOP cycle is guaranteed between operations. An end pulse in a non-matching state is ignored.
- Pin stage: selected cmd/addr, wr_dq and (state==S_WRITE & wr_dq_en) are registered together into the pins.
  - Fixed 1-cycle latency stage->pin; data and oe stay aligned with the WRITE command.
  - dq_oe=0 outside S_WRITE.
- Reset mid-operation: everything returns to reset values; init must rerun.

Decomposition:
- Shared package sdram_pkg:
  - command constants CMD_NOP 0111, CMD_PRE 0010, CMD_AREF 0001, CMD_ACT 0011, CMD_WR 0100, CMD_RD 0101, CMD_MRS 0000;
  - state encodings;
  - DQ_W default.
- No sub-module needed; the pin register stage may be a small sdram_pin_reg if pad constraints demand.

Test Plan:
- Reset release, init_cmd=0010 then init_end pulse at cycle 10 -> pins show 0010 one cycle after applied, state S_ARBIT at cycle 11, cke=1 from first post-reset edge.
- wr_ask=1 in S_ARBIT -> wr_en=1 next cycle. wr_cmd=0100 with wr_dq=16'hA5A5, wr_dq_en=1 -> pins 0100, dq_out=A5A5, oe=1 one cycle later. wr_end -> wr_en=0 same edge, NOP next.
- ref_req, wr_ask, rd_ask all high in S_ARBIT -> ref_en first; after ref_end, write and read alternate (WR then RD when last_grant=RD).
- ref_req raised mid-write -> wr_en low next cycle, state held in S_WRITE until wr_end. Then ref_en=1 after one NOP cycle, then wr_en=1 again with wr_ask still high.
- srst pulsed during S_READ -> all outputs at reset values immediately (async), rd_en=0. rd_end afterwards is ignored until init_end.
